// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the debug register dumper.
// SM_REGDUMP_ADDR_EN adds a "AA:" address prefix to every dumped line.
package sm_regdump_pkg;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_CAPT,
    RD_SEND,
    RD_WAIT,
    RD_FIN
  } rdState_t;

  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_A     = 8'h41;

`ifdef SM_REGDUMP_ADDR_EN
  localparam int unsigned PREFIX_BYTES = 3;
`else
  localparam int unsigned PREFIX_BYTES = 0;
`endif
  localparam int unsigned LINE_BYTES = PREFIX_BYTES + 9;
  localparam int unsigned CHAR_W     = 4;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hexChar(input logic [3:0] nib);
    return (nib < 4'd10) ? (ASC_0 + 8'(nib)) : (ASC_A + 8'(nib - 4'd10));
  endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// UART 8N1 transmitter; ready rises in the last stop-bit cycle so frames
// can be sent back to back with a period of exactly 10*CLK_DIV cycles.
module sm_uart_tx #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] divCnt;
  logic [3:0]       bitCnt;
  logic [8:0]       shiftReg;
  logic             active;
  logic             bitEnd;

  assign bitEnd = (divCnt == DIV_W'(CLK_DIV - 1));
  assign ready  = !active || (bitEnd && (bitCnt == 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '1;
      active   <= 1'b0;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      // start bit goes out immediately, data then stop follow from shiftReg
      active   <= 1'b1;
      divCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= {1'b1, data};
      tx       <= 1'b0;
    end else if (active) begin
      if (bitEnd) begin
        divCnt <= '0;
        if (bitCnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          bitCnt   <= bitCnt + 4'd1;
          tx       <= shiftReg[0];
          shiftReg <= {1'b1, shiftReg[8:1]};
        end
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Walks debug register indices 0..NUM_REGS-1 and prints each as an ASCII hex
// line over UART. Build option: SM_REGDUMP_ADDR_EN (address prefix per line).
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 434,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0]        LAST_ADDR = 5'(NUM_REGS - 1);
  localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(LINE_BYTES - 1);

  rdState_t          state;
  logic [31:0]       shadow;
  logic [CHAR_W-1:0] charIdx;
  logic [2:0]        nibSel;
  logic [7:0]        txByte;
  logic              txValid;
  logic              txReady;

  // Nibble k (MSB first) sits at bit offset 4*(7-k) = {~k, 2'b00}
  assign nibSel = 3'(charIdx - CHAR_W'(PREFIX_BYTES));

  always_comb begin
    txByte = ASC_LF;
`ifdef SM_REGDUMP_ADDR_EN
    if (charIdx == CHAR_W'(0)) begin
      txByte = hexChar({3'b000, regAddr[4]});
    end else if (charIdx == CHAR_W'(1)) begin
      txByte = hexChar(regAddr[3:0]);
    end else if (charIdx == CHAR_W'(2)) begin
      txByte = ASC_COLON;
    end else if (charIdx != LAST_CHAR) begin
      txByte = hexChar(shadow[{~nibSel, 2'b00} +: 4]);
    end
`else
    if (charIdx != LAST_CHAR) begin
      txByte = hexChar(shadow[{~nibSel, 2'b00} +: 4]);
    end
`endif
  end

  assign txValid = (state == RD_SEND) && txReady;

  // Walker FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RD_IDLE;
      regAddr <= '0;
      shadow  <= '0;
      charIdx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (start) begin
            regAddr <= '0;
            busy    <= 1'b1;
            state   <= RD_CAPT;
          end
        end
        RD_CAPT: begin
          shadow  <= regData;
          charIdx <= '0;
          state   <= RD_SEND;
        end
        RD_SEND: begin
          if (txReady) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (txReady) begin
            if (charIdx == LAST_CHAR) begin
              if (regAddr == LAST_ADDR) begin
                done  <= 1'b1;
                state <= RD_FIN;
              end else begin
                regAddr <= regAddr + 5'd1;
                state   <= RD_CAPT;
              end
            end else begin
              charIdx <= charIdx + CHAR_W'(1);
              state   <= RD_SEND;
            end
          end
        end
        RD_FIN: begin
          busy  <= 1'b0;
          state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  sm_uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) uUart (
    .clk  (clk),
    .rst_n(rst_n),
    .data (txByte),
    .valid(txValid),
    .ready(txReady),
    .tx   (tx)
  );

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump: UART decoder feeding a byte scoreboard.
// Honours SM_REGDUMP_ADDR_EN when building the expected lines.
module tb_sm_regdump;

  localparam int CLK_DIV  = 4;
  localparam int NUM_REGS = 3;
`ifdef SM_REGDUMP_ADDR_EN
  localparam int LB = 12;
`else
  localparam int LB = 9;
`endif
  localparam int DUMP_BYTES = NUM_REGS * LB;
  localparam int MIN_CYC    = DUMP_BYTES * 10 * CLK_DIV;
  localparam int MAX_CYC    = MIN_CYC + DUMP_BYTES * 4 + 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx, busy, done;

  logic        dataMode = 1'b0;
  logic [31:0] fixedVal = 32'h0;

  int tests = 0;
  int failed = 0;
  int epoch = 0;
  int rxCount = 0;
  int doneCnt = 0;
  logic [7:0] expQ[$];
  logic [4:0] addrLog[$];
  logic [4:0] lastA = 5'd0;

  always #5 clk = ~clk;

  assign regData = dataMode ? fixedVal : (32'(regAddr) * 32'h11111111);

  sm_regdump #(
    .CLK_DIV (CLK_DIV),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .regAddr(regAddr),
    .regData(regData),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pushLine(input logic [4:0] a, input logic [31:0] v);
    string hx = "0123456789ABCDEF";
`ifdef SM_REGDUMP_ADDR_EN
    expQ.push_back(hx[a[4] ? 1 : 0]);
    expQ.push_back(hx[int'(a[3:0])]);
    expQ.push_back(8'h3A);
`endif
    for (int i = 7; i >= 0; i--) expQ.push_back(hx[int'(v[i*4 +: 4])]);
    expQ.push_back(8'h0A);
  endtask

  task automatic pushDump();
    for (int a = 0; a < NUM_REGS; a++)
      pushLine(5'(a), dataMode ? fixedVal : (32'(a) * 32'h11111111));
  endtask

  task automatic waitDone(input string tag, output int cyc);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
    cyc = n;
  endtask

  always @(posedge clk) if (done === 1'b1) doneCnt++;

  always @(negedge clk) begin
    if (busy === 1'b1 && regAddr !== lastA) addrLog.push_back(regAddr);
    lastA = regAddr;
  end

  // UART decoder: samples mid-bit and pops the scoreboard per byte
  initial begin : uartMon
    logic [7:0] b;
    logic [7:0] e;
    int ep;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ep = epoch;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (ep == epoch) begin
          rxCount++;
          check("stop_bit", 32'(tx), 32'd1);
          tests++;
          assert (expQ.size() != 0) else begin
            failed++;
            $error("FAIL rx_unexpected: got %h expected none", b);
          end
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            check("rx_byte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  initial begin : stim
    int cyc, base, rxBase, n, lowCnt;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(regAddr), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);

    // constant DEADBEEF on every index
    dataMode = 1'b1;
    fixedVal = 32'hDEADBEEF;
    rxBase = rxCount;
    pushDump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
    waitDone("dump_a_done", cyc);
    check("dump_a_min", 32'(cyc >= MIN_CYC), 32'd1);
    check("dump_a_max", 32'(cyc <= MAX_CYC), 32'd1);
    check("dump_a_last_addr", 32'(regAddr), 32'(NUM_REGS - 1));
    @(negedge clk);
    check("dump_a_busy_off", 32'(busy), 32'd0);
    check("dump_a_done_pulse", 32'(done), 32'd0);
    check("dump_a_bytes", 32'(rxCount - rxBase), 32'(DUMP_BYTES));
    check("dump_a_queue", 32'(expQ.size()), 32'd0);

    // per-index values regAddr*0x11111111
    dataMode = 1'b0;
    addrLog.delete();
    pushDump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("dump_b_done", cyc);
    check("dump_b_last_addr", 32'(regAddr), 32'd2);
    check("addr_log_len", 32'(addrLog.size()), 32'd3);
    for (int i = 0; i < 3 && i < addrLog.size(); i++) check("addr_seq", 32'(addrLog[i]), 32'(i));
    repeat (2) @(negedge clk);
    check("dump_b_queue", 32'(expQ.size()), 32'd0);

    // snapshot: value changes two cycles after first capture
    dataMode = 1'b1;
    fixedVal = 32'hCAFEF00D;
    pushLine(5'd0, 32'hCAFEF00D);
    for (int a = 1; a < NUM_REGS; a++) pushLine(5'(a), 32'h12345678);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 fixedVal = 32'h12345678;
    waitDone("snap_done", cyc);
    repeat (2) @(negedge clk);
    check("snap_queue", 32'(expQ.size()), 32'd0);

    // start held high with extra pulses: one dump per acceptance
    dataMode = 1'b0;
    base = doneCnt;
    pushDump();
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    waitDone("held_done1", cyc);
    pushDump();
    @(negedge clk);
    check("held_fin_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone("held_done2", cyc);
    repeat (5) @(negedge clk);
    check("held_busy_off", 32'(busy), 32'd0);
    check("held_done_count", 32'(doneCnt - base), 32'd2);
    check("held_queue", 32'(expQ.size()), 32'd0);

    // reset in the middle of data bit 4 of char 3
    dataMode = 1'b1;
    fixedVal = 32'hDEADBEEF;
    rxBase = rxCount;
    pushDump();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rxCount < rxBase + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_bytes", 32'(rxCount - rxBase), 32'd3);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_start", 32'(tx), 32'd0);
    repeat (22) @(negedge clk);
    check("pre_reset_bit4", 32'(tx), 32'd0);
    epoch++;
    expQ.delete();
    base = doneCnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(regAddr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lowCnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lowCnt++;
    end
    check("post_rst_tx_low_cycles", 32'(lowCnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(doneCnt - base), 32'd0);
    check("final_queue", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
